// File: rtl/lcd_capture_if.sv
// Video strobe inputs from the gameboy core plus framebuffer write and status outputs.
// The video source / testbench uses master; lcd_capture uses slave.
interface lcd_capture_if #(
  parameter int AW = 13
) ();
  logic          cap_enable;
  logic          clear_err;
  logic [1:0]    pixel_data;
  logic          pixel_clock;
  logic          pixel_latch;
  logic          hsync;
  logic          vsync;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          fb_we;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          line_err;
  logic          frame_err;

  modport master (
    output cap_enable, clear_err, pixel_data, pixel_clock, pixel_latch, hsync, vsync,
    input  fb_addr, fb_data, fb_we, frame_done, frame_count, line_err, frame_err
  );

  modport slave (
    input  cap_enable, clear_err, pixel_data, pixel_clock, pixel_latch, hsync, vsync,
    output fb_addr, fb_data, fb_we, frame_done, frame_count, line_err, frame_err
  );
endinterface

// File: rtl/lcd_capture.sv
// Packs gameboy video (2bpp, 4 px/byte) into framebuffer byte writes; counts frames, flags bad lines/frames.
// Write strobe is registered 1 cycle after the sampling edge; no backpressure, the sink must accept every write.
module lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int AW       = 13
) (
  input  logic         clock,
  input  logic         reset,
  lcd_capture_if.slave bus
);
  localparam int HB = H_PIXELS / 4;
  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_DONE} state_t;

  state_t        r_state, w_state_n;
  logic          r_pclk_q, r_lend_q, r_vs_q;
  logic          w_px_rise, w_lend_rise, w_vs_rise;
  logic [LW-1:0] r_line, w_line_n;
  logic [PW-1:0] r_px, w_px_n, w_px_t;
  logic [7:0]    r_pack, w_pack_n, w_pack_t;
  logic          r_fb_we, w_fb_we_n;
  logic [AW-1:0] r_fb_addr, w_fb_addr_n;
  logic [7:0]    r_fb_data, w_fb_data_n;
  logic          r_frame_done, w_frame_done_n;
  logic [7:0]    r_frame_count, w_frame_count_n;
  logic          r_line_err, w_line_err_n;
  logic          r_frame_err, w_frame_err_n;
  logic [AW-1:0] w_base;

  assign w_px_rise   = bus.pixel_clock & ~r_pclk_q;
  assign w_lend_rise = (bus.hsync | bus.pixel_latch) & ~r_lend_q;
  assign w_vs_rise   = bus.vsync & ~r_vs_q;
  assign w_base      = AW'(r_line) * AW'(HB);

  always_comb begin
    w_state_n       = r_state;
    w_line_n        = r_line;
    w_px_n          = r_px;
    w_pack_n        = r_pack;
    w_px_t          = r_px;
    w_pack_t        = r_pack;
    w_fb_we_n       = 1'b0;
    w_fb_addr_n     = r_fb_addr;
    w_fb_data_n     = r_fb_data;
    w_frame_done_n  = 1'b0;
    w_frame_count_n = r_frame_count;
    // clear first so that an error raised this cycle overrides the clear
    w_line_err_n    = r_line_err & ~bus.clear_err;
    w_frame_err_n   = r_frame_err & ~bus.clear_err;

    if (!bus.cap_enable) begin
      w_state_n = S_IDLE;
    end else if (w_vs_rise) begin
      if (r_state == S_LINE || r_state == S_HBLANK) w_frame_err_n = 1'b1;
      w_line_n  = '0;
      w_px_n    = '0;
      w_pack_n  = '0;
      w_state_n = S_LINE;
    end else begin
      case (r_state)
        S_LINE, S_HBLANK: begin
          if (w_px_rise) begin
            if (r_state == S_LINE) begin
              w_pack_t = {r_pack[5:0], bus.pixel_data};
              w_px_t   = r_px + PW'(1);
              if (w_px_t[1:0] == 2'b00) begin
                w_fb_we_n   = 1'b1;
                w_fb_addr_n = w_base + AW'(r_px >> 2);
                w_fb_data_n = w_pack_t;
              end
              if (w_px_t == PW'(H_PIXELS)) w_state_n = S_HBLANK;
            end else begin
              w_line_err_n = 1'b1;
            end
          end
          w_pack_n = w_pack_t;
          w_px_n   = w_px_t;
          // a same-cycle pixel is already folded into w_px_t/w_pack_t
          if (w_lend_rise) begin
            if (r_state == S_LINE && w_px_t != PW'(H_PIXELS)) begin
              w_line_err_n = 1'b1;
              if (w_px_t[1:0] != 2'b00) begin
                w_fb_we_n   = 1'b1;
                w_fb_addr_n = w_base + AW'(w_px_t >> 2);
                case (w_px_t[1:0])
                  2'd1:    w_fb_data_n = {w_pack_t[1:0], 6'b0};
                  2'd2:    w_fb_data_n = {w_pack_t[3:0], 4'b0};
                  default: w_fb_data_n = {w_pack_t[5:0], 2'b0};
                endcase
              end
            end
            w_px_n   = '0;
            w_line_n = r_line + LW'(1);
            if (r_line == LW'(V_LINES - 1)) begin
              w_frame_done_n  = 1'b1;
              w_frame_count_n = r_frame_count + 8'd1;
              w_state_n       = S_DONE;
            end else begin
              w_state_n = S_LINE;
            end
          end
        end
        S_DONE: begin
          if (w_px_rise) w_frame_err_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pclk_q      <= 1'b0;
      r_lend_q      <= 1'b0;
      r_vs_q        <= 1'b0;
      r_line        <= '0;
      r_px          <= '0;
      r_pack        <= '0;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_pclk_q      <= bus.pixel_clock;
      r_lend_q      <= bus.hsync | bus.pixel_latch;
      r_vs_q        <= bus.vsync;
      r_line        <= w_line_n;
      r_px          <= w_px_n;
      r_pack        <= w_pack_n;
      r_fb_we       <= w_fb_we_n;
      r_fb_addr     <= w_fb_addr_n;
      r_fb_data     <= w_fb_data_n;
      r_frame_done  <= w_frame_done_n;
      r_frame_count <= w_frame_count_n;
      r_line_err    <= w_line_err_n;
      r_frame_err   <= w_frame_err_n;
    end
  end

  assign bus.fb_we       = r_fb_we;
  assign bus.fb_addr     = r_fb_addr;
  assign bus.fb_data     = r_fb_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;
  assign bus.line_err    = r_line_err;
  assign bus.frame_err   = r_frame_err;
endmodule

// File: tb/tb_lcd_capture.sv
// Scoreboard bench for lcd_capture: expected writes queued as pixels are driven,
// popped and compared whenever the DUT strobes fb_we.
module tb_lcd_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_capture_if #(.AW(13)) bus ();

  lcd_capture #(.H_PIXELS(160), .V_LINES(144), .AW(13)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_run    = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.fb_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(bus.fb_we), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(bus.fb_addr), 32'(mon_e.a));
        check("wr_data", 32'(bus.fb_data), 32'(mon_e.d));
      end
    end
  end

  task automatic push(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 13'(a);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic px(input logic [1:0] v);
    @(negedge clk);
    bus.pixel_data  = v;
    bus.pixel_clock = 1'b1;
    @(negedge clk);
    bus.pixel_clock = 1'b0;
  endtask

  task automatic hs(input bit use_latch);
    @(negedge clk);
    if (use_latch) bus.pixel_latch = 1'b1;
    else           bus.hsync       = 1'b1;
    @(negedge clk);
    bus.pixel_latch = 1'b0;
    bus.hsync       = 1'b0;
  endtask

  task automatic vs();
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(bus.fb_we),       32'd0);
    check({tag, "_addr"},  32'(bus.fb_addr),     32'd0);
    check({tag, "_data"},  32'(bus.fb_data),     32'd0);
    check({tag, "_done"},  32'(bus.frame_done),  32'd0);
    check({tag, "_count"}, 32'(bus.frame_count), 32'd0);
    check({tag, "_lerr"},  32'(bus.line_err),    32'd0);
    check({tag, "_ferr"},  32'(bus.frame_err),   32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cap_enable  = 1'b0;
    bus.clear_err   = 1'b0;
    bus.pixel_data  = 2'd0;
    bus.pixel_clock = 1'b0;
    bus.pixel_latch = 1'b0;
    bus.hsync       = 1'b0;
    bus.vsync       = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // nominal frame, line 5 ended with pixel_latch instead of hsync
    bus.cap_enable = 1'b1;
    vs();
    for (int l = 0; l < 144; l++) begin
      for (int g = 0; g < 40; g++) push(l * 40 + g, 8'h1B);
      for (int p = 0; p < 160; p++) px(2'(p % 4));
      hs(l == 5);
    end
    settle("nom_sb");
    check("nom_done_cnt", 32'(done_cnt), 32'd1);
    check("nom_count", 32'(bus.frame_count), 32'd1);
    check("nom_lerr", 32'(bus.line_err), 32'd0);
    check("nom_ferr", 32'(bus.frame_err), 32'd0);

    // latency and packing on line 2
    vs();
    for (int l = 0; l < 2; l++) begin
      for (int g = 0; g < 40; g++) push(l * 40 + g, 8'h00);
      for (int p = 0; p < 160; p++) px(2'd0);
      hs(1'b0);
    end
    push(80, 8'hC9);
    px(2'd3);
    px(2'd0);
    px(2'd2);
    @(negedge clk);
    bus.pixel_data  = 2'd1;
    bus.pixel_clock = 1'b1;
    check("lat_we_pre", 32'(bus.fb_we), 32'd0);
    @(posedge clk);
    #1;
    check("lat_we", 32'(bus.fb_we), 32'd1);
    check("lat_addr", 32'(bus.fb_addr), 32'd80);
    check("lat_data", 32'(bus.fb_data), 32'hC9);
    @(negedge clk);
    bus.pixel_clock = 1'b0;
    @(posedge clk);
    #1;
    check("lat_we_post", 32'(bus.fb_we), 32'd0);
    settle("lat_sb");
    check("lat_ferr", 32'(bus.frame_err), 32'd0);

    // short line: 6 pixels then hsync
    vs();
    check("short_pre_ferr", 32'(bus.frame_err), 32'd1);
    clr();
    check("short_clr_ferr", 32'(bus.frame_err), 32'd0);
    push(0, 8'hFF);
    push(1, 8'hF0);
    for (int p = 0; p < 6; p++) px(2'd3);
    hs(1'b0);
    settle("short_sb");
    check("short_lerr", 32'(bus.line_err), 32'd1);
    push(40, 8'h55);
    for (int p = 0; p < 4; p++) px(2'd1);
    settle("short_next_sb");

    // long line: 164 pixels, extras dropped
    vs();
    clr();
    check("long_clr_lerr", 32'(bus.line_err), 32'd0);
    for (int g = 0; g < 40; g++) push(g, 8'hAA);
    for (int p = 0; p < 164; p++) px(2'd2);
    hs(1'b0);
    settle("long_sb");
    check("long_lerr", 32'(bus.line_err), 32'd1);
    push(40, 8'h00);
    for (int p = 0; p < 4; p++) px(2'd0);
    settle("long_next_sb");

    // vsync after line 10, pixel 50
    vs();
    clr();
    for (int l = 0; l < 10; l++) begin
      for (int g = 0; g < 40; g++) push(l * 40 + g, 8'h1B);
      for (int p = 0; p < 160; p++) px(2'(p % 4));
      hs(1'b0);
    end
    for (int g = 0; g < 12; g++) push(400 + g, 8'h1B);
    for (int p = 0; p < 50; p++) px(2'(p % 4));
    vs();
    settle("vsm_sb");
    check("vsm_ferr", 32'(bus.frame_err), 32'd1);
    check("vsm_lerr", 32'(bus.line_err), 32'd0);
    check("vsm_done_cnt", 32'(done_cnt), 32'd1);
    push(0, 8'hFF);
    for (int p = 0; p < 4; p++) px(2'd3);
    settle("vsm_next_sb");
    clr();
    check("vsm_clr_ferr", 32'(bus.frame_err), 32'd0);
    check("vsm_clr_lerr", 32'(bus.line_err), 32'd0);

    // disable mid-line: no writes until the next vsync
    px(2'd3);
    px(2'd3);
    @(negedge clk);
    bus.cap_enable = 1'b0;
    px(2'd3);
    px(2'd3);
    hs(1'b0);
    @(negedge clk);
    bus.cap_enable = 1'b1;
    for (int p = 0; p < 8; p++) px(2'd1);
    hs(1'b0);
    settle("dis_sb");
    check("dis_count_kept", 32'(bus.frame_count), 32'd1);
    vs();
    push(0, 8'h55);
    for (int p = 0; p < 4; p++) px(2'd1);
    settle("dis_resume_sb");

    // reset mid-line
    px(2'd2);
    px(2'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    for (int p = 0; p < 8; p++) px(2'd3);
    settle("rst_idle_sb");
    vs();
    push(0, 8'hFF);
    for (int p = 0; p < 4; p++) px(2'd3);
    settle("rst_resume_sb");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
